// File: rtl/ball_scene_ctrl_pkg.sv
// Shared definitions for the bouncing-ball scene controller: FSM encodings,
// frame boundary defaults and the ball-pair <-> pair-index mapping.
package ball_scene_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_STEP  = 2'd3;

    localparam int DEF_FRAME_X = 0;
    localparam int DEF_FRAME_Y = 500;
    localparam int MAX_BALLS   = 8;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } pair_t;

    // Pairs are enumerated (0,1),(0,2)..(0,N-1),(1,2).. so index 0 is lowest.
    function automatic pair_t pair_of(input int nballs, input int p);
        pair_t r;
        int    idx;
        r   = '0;
        idx = 0;
        for (int a = 0; a < MAX_BALLS; a++) begin
            for (int b = 0; b < MAX_BALLS; b++) begin
                if (b > a && b < nballs) begin
                    if (idx == p) begin
                        r.a = 3'(a);
                        r.b = 3'(b);
                    end
                    idx++;
                end
            end
        end
        return r;
    endfunction

    function automatic int pair_index(input int nballs, input int a, input int b);
        int idx;
        int res;
        idx = 0;
        res = 0;
        for (int i = 0; i < MAX_BALLS; i++) begin
            for (int j = 0; j < MAX_BALLS; j++) begin
                if (j > i && j < nballs) begin
                    if (i == a && j == b) res = idx;
                    idx++;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_scene_ctrl_serializer.sv
// Holds one frame's worth of ball-pair hits and presents them one per clock,
// lowest pair first, on a valid/ready stream with a sticky drop flag.
module ball_evt_serializer
    import ball_scene_ctrl_pkg::*;
#(
    parameter int NBALLS = 4,
    parameter int NPAIRS = NBALLS * (NBALLS - 1) / 2,
    parameter int IW     = $clog2(NBALLS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [NPAIRS-1:0] load_bits,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [IW-1:0]     evt_a,
    output logic [IW-1:0]     evt_b,
    output logic              evt_ovf
);

    logic [NPAIRS-1:0] pending;
    logic [NPAIRS-1:0] lowest;
    logic [NPAIRS-1:0] remaining;
    logic [NPAIRS-1:0] pending_d;
    int                pick_idx;
    pair_t             pick;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        lowest    = pending & (~pending + NPAIRS'(1));
        remaining = (evt_valid && evt_ready) ? (pending & ~lowest) : pending;
        pending_d = load ? load_bits : remaining;
        pick_idx  = 0;
        for (int p = NPAIRS - 1; p >= 0; p--) begin
            if (pending_d[p]) pick_idx = p;
        end
        pick = pair_of(NBALLS, pick_idx);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: pending is a handful of flops, not a RAM, so it is reset like any
    // other control register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_a     <= '0;
            evt_b     <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            pending   <= pending_d;
            evt_valid <= |pending_d;
            // Indices only move on accept or reload, so they hold under backpressure.
            if (|pending_d) begin
                evt_a <= IW'(pick.a);
                evt_b <= IW'(pick.b);
            end
            // An event accepted in the loading cycle counts as delivered, not dropped.
            if (load && (|remaining)) begin
                evt_ovf <= 1'b1;
            end else if (clr_ovf) begin
                evt_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ball_scene_ctrl.sv
// Frame sequencer and collision arbiter for the bouncing-ball scene: run/pause/
// step FSM, per-frame update strobe, overlap flags and pair-hit event stream.
module ball_scene_ctrl
    import ball_scene_ctrl_pkg::*;
#(
    parameter int  NBALLS  = 4,
    parameter int  FRAME_Y = DEF_FRAME_Y,
    parameter int  FRAME_X = DEF_FRAME_X,
    localparam int IW      = $clog2(NBALLS),
    localparam int NPAIRS  = NBALLS * (NBALLS - 1) / 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [9:0]        CounterX,
    input  logic [8:0]        CounterY,
    input  logic [NBALLS-1:0] inball,
    input  logic              run,
    input  logic              step,
    output logic [NBALLS-1:0] inotherball,
    output logic              update_en,
    output logic              frame_tick,
    output logic [15:0]       frame_count,
    output logic [1:0]        state,
    output logic              evt_valid,
    output logic [IW-1:0]     evt_a,
    output logic [IW-1:0]     evt_b,
    input  logic              evt_ready,
    output logic              evt_ovf,
    input  logic              clr_ovf
);

    localparam logic [9:0] FX = 10'(FRAME_X);
    localparam logic [8:0] FY = 9'(FRAME_Y);

    logic              frame_match;
    logic [1:0]        state_d;
    logic              capture;
    logic [NBALLS-1:0] overlap;
    logic [NPAIRS-1:0] hit_now;
    logic [NPAIRS-1:0] pair_hit;
    logic [NPAIRS-1:0] load_bits;

    assign frame_match = (CounterY == FY) && (CounterX == FX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) frame_tick <= 1'b0;
        else       frame_tick <= frame_match;
    end

    // run always wins over step; STEP falls back to PAUSE once its frame is done.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (run) state_d = ST_RUN;
            ST_RUN:   if (!run) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (run)       state_d = ST_RUN;
                else if (step) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (run)             state_d = ST_RUN;
                else if (frame_tick) state_d = ST_PAUSE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_d;
    end

    assign capture   = (state == ST_RUN) || (state == ST_STEP);
    assign update_en = frame_tick && capture;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          frame_count <= '0;
        else if (update_en) frame_count <= frame_count + 16'd1;
    end

    for (genvar i = 0; i < NBALLS; i++) begin : g_overlap
        assign overlap[i] = inball[i] & (|(inball & ~(NBALLS'(1) << i)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) inotherball <= '0;
        else       inotherball <= overlap;
    end

    for (genvar a = 0; a < NBALLS; a++) begin : g_a
        for (genvar b = a + 1; b < NBALLS; b++) begin : g_b
            assign hit_now[pair_index(NBALLS, a, b)] = inball[a] & inball[b];
        end
    end

    // Hits accumulate only while animating; a held scene never queues events.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                        pair_hit <= '0;
        else if (!capture || frame_tick)  pair_hit <= '0;
        else                              pair_hit <= pair_hit | hit_now;
    end

    // The boundary cycle's own overlap belongs to the frame being closed.
    assign load_bits = capture ? (pair_hit | hit_now) : '0;

    ball_evt_serializer #(
        .NBALLS (NBALLS),
        .NPAIRS (NPAIRS),
        .IW     (IW)
    ) u_evt (
        .clk       (clk),
        .rstn      (rstn),
        .load      (frame_tick),
        .load_bits (load_bits),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_a     (evt_a),
        .evt_b     (evt_b),
        .evt_ovf   (evt_ovf)
    );

endmodule

// File: tb/tb_ball_scene_ctrl.sv
// Self-checking bench for ball_scene_ctrl: directed scenarios plus random
// traffic against a frame-level reference model and an event scoreboard.
module tb_ball_scene_ctrl;

    localparam int N       = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_STEP  = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic [N-1:0] inball;
    logic        run, step, evt_ready, clr_ovf;

    logic [N-1:0] inotherball;
    logic        update_en, frame_tick, evt_valid, evt_ovf;
    logic [15:0] frame_count;
    logic [1:0]  state;
    logic [1:0]  evt_a, evt_b;

    ball_scene_ctrl #(.NBALLS(N), .FRAME_Y(500), .FRAME_X(0)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .CounterX    (cx),
        .CounterY    (cy),
        .inball      (inball),
        .run         (run),
        .step        (step),
        .inotherball (inotherball),
        .update_en   (update_en),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .state       (state),
        .evt_valid   (evt_valid),
        .evt_a       (evt_a),
        .evt_b       (evt_b),
        .evt_ready   (evt_ready),
        .evt_ovf     (evt_ovf),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int a; int b; } pr_t;

    pr_t         m_pend[$];
    pr_t         exp_q[$];
    bit          m_hit[N][N];
    int          m_st;
    bit          m_ft;
    bit          m_ovf;
    logic [15:0] m_cnt;
    logic [N-1:0] m_iob;

    task automatic model_reset();
        m_pend.delete();
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++) m_hit[a][b] = 1'b0;
        m_st  = S_IDLE;
        m_ft  = 1'b0;
        m_ovf = 1'b0;
        m_cnt = '0;
        m_iob = '0;
    endtask

    task automatic model_advance();
        bit           cap;
        int           ones;
        logic [N-1:0] ib;
        pr_t          p;
        pr_t          fresh[$];
        int           st_n;
        ib  = inball;
        cap = (m_st == S_RUN) || (m_st == S_STEP);
        if (m_pend.size() > 0 && evt_ready) exp_q.push_back(m_pend.pop_front());
        if (m_ft) begin
            if (cap) begin
                for (int a = 0; a < N; a++)
                    for (int b = a + 1; b < N; b++)
                        if (m_hit[a][b] || (ib[a] && ib[b])) begin
                            p.a = a; p.b = b;
                            fresh.push_back(p);
                        end
            end
            if (m_pend.size() > 0) m_ovf = 1'b1;
            else if (clr_ovf)      m_ovf = 1'b0;
            m_pend = fresh;
            for (int a = 0; a < N; a++)
                for (int b = 0; b < N; b++) m_hit[a][b] = 1'b0;
        end else begin
            if (clr_ovf) m_ovf = 1'b0;
            for (int a = 0; a < N; a++)
                for (int b = a + 1; b < N; b++)
                    m_hit[a][b] = cap && (m_hit[a][b] || (ib[a] && ib[b]));
        end
        ones = $countones(ib);
        for (int i = 0; i < N; i++) m_iob[i] = ib[i] && (ones >= 2);
        if (m_ft && cap) m_cnt = m_cnt + 16'd1;
        st_n = m_st;
        if (m_st == S_IDLE && run)           st_n = S_RUN;
        else if (m_st == S_RUN && !run)      st_n = S_PAUSE;
        else if (m_st == S_PAUSE && run)     st_n = S_RUN;
        else if (m_st == S_PAUSE && step)    st_n = S_STEP;
        else if (m_st == S_STEP && run)      st_n = S_RUN;
        else if (m_st == S_STEP && m_ft)     st_n = S_PAUSE;
        m_st = st_n;
        m_ft = (cx == 10'd0) && (cy == 9'd500);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            #1;
            if (!rstn) model_reset();
            else       model_advance();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit         hs;
        logic [1:0] sa, sb;
        pr_t        e;
        forever begin
            @(negedge clk);
            check("m_state",  state,       m_st);
            check("m_count",  frame_count, m_cnt);
            check("m_iob",    inotherball, m_iob);
            check("m_tick",   frame_tick,  m_ft);
            check("m_upd",    update_en,   m_ft && (m_st == S_RUN || m_st == S_STEP));
            check("m_valid",  evt_valid,   m_pend.size() > 0);
            check("m_ovf",    evt_ovf,     m_ovf);
            if (m_pend.size() > 0) begin
                check("m_show_a", evt_a, m_pend[0].a);
                check("m_show_b", evt_b, m_pend[0].b);
            end
            hs = evt_valid && evt_ready;
            sa = evt_a;
            sb = evt_b;
            @(posedge clk);
            #3;
            if (hs) begin
                check("sb_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_evt_a", sa, e.a);
                    check("sb_evt_b", sb, e.b);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic frame();
        cx = 10'd0; cy = 9'd500;
        cyc();
        cx = 10'd100; cy = 9'd100;
        cyc();
    endtask

    initial begin
        int k;
        cx = 10'd100; cy = 9'd100; inball = '0;
        run = 1'b1; step = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
        rstn = 1'b0;
        repeat (3) cyc();

        // T1 reset
        check("t1_state",   state, 0);
        check("t1_count",   frame_count, 0);
        check("t1_upd",     update_en, 0);
        check("t1_valid",   evt_valid, 0);
        check("t1_ovf",     evt_ovf, 0);
        check("t1_iob",     inotherball, 0);
        rstn = 1'b1;
        cyc();
        check("t1_run", state, 1);
        cx = 10'd0; cy = 9'd500;
        cyc();
        check("t1_tick", frame_tick, 1);
        check("t1_upd1", update_en, 1);
        cx = 10'd100; cy = 9'd100;
        cyc();
        check("t1_count1", frame_count, 1);

        // T2 run / pause / step
        frame(); frame();
        check("t2_count3", frame_count, 3);
        run = 1'b0;
        cyc();
        check("t2_pause", state, 2);
        frame(); frame();
        check("t2_hold", frame_count, 3);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("t2_step", state, 3);
        cx = 10'd0; cy = 9'd500;
        cyc();
        check("t2_step_upd", update_en, 1);
        cx = 10'd100; cy = 9'd100;
        cyc();
        check("t2_count4", frame_count, 4);
        check("t2_back", state, 2);

        // T3 overlap
        run = 1'b1;
        cyc();
        inball = 4'b0101;
        cyc();
        check("t3_iob", inotherball, 4'b0101);
        inball = 4'b0001;
        cyc();
        check("t3_iob_single", inotherball, 0);
        inball = 4'b0000;
        frame();
        check("t3_valid", evt_valid, 1);
        check("t3_a", evt_a, 0);
        check("t3_b", evt_b, 2);
        evt_ready = 1'b1;
        cyc();
        check("t3_done", evt_valid, 0);
        evt_ready = 1'b0;

        // T4 serial events
        inball = 4'b0011; cyc();
        inball = 4'b1100; cyc();
        inball = 4'b0000;
        frame();
        check("t4_a0", evt_a, 0);
        check("t4_b0", evt_b, 1);
        evt_ready = 1'b1;
        cyc();
        check("t4_v1", evt_valid, 1);
        check("t4_a1", evt_a, 2);
        check("t4_b1", evt_b, 3);
        cyc();
        check("t4_empty", evt_valid, 0);
        evt_ready = 1'b0;

        // T5 backpressure / overflow
        inball = 4'b0011; cyc();
        inball = 4'b0000;
        frame();
        check("t5_first", evt_b, 1);
        inball = 4'b0110; cyc();
        inball = 4'b0000;
        frame();
        check("t5_ovf", evt_ovf, 1);
        check("t5_a", evt_a, 1);
        check("t5_b", evt_b, 2);
        evt_ready = 1'b1;
        cyc();
        check("t5_only", evt_valid, 0);
        evt_ready = 1'b0;
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("t5_clr", evt_ovf, 0);

        // T6 priority and wrap
        run = 1'b0;
        cyc();
        check("t6_pause", state, 2);
        run = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        check("t6_prio", state, 1);
        k = 32'h10000 - int'(m_cnt);
        cx = 10'd0; cy = 9'd500;
        repeat (k) cyc();
        check("t6_ffff", frame_count, 16'hFFFF);
        cx = 10'd100; cy = 9'd100;
        cyc();
        check("t6_wrap", frame_count, 0);

        // Random traffic with a mid-frame reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1800) rstn = 1'b0;
            if (c == 1803) rstn = 1'b1;
            if ($urandom_range(0, 24) == 0) begin
                cx = 10'd0; cy = 9'd500;
            end else begin
                cx = 10'($urandom_range(0, 799));
                cy = 9'($urandom_range(0, 511));
            end
            inball    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 99) < 3) run = ~run;
            step      = ($urandom_range(0, 19) == 0);
            evt_ready = ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 29) == 0);
            cyc();
        end

        // Drain
        run = 1'b1; step = 1'b0; inball = '0; evt_ready = 1'b1; clr_ovf = 1'b0;
        cx = 10'd100; cy = 9'd100;
        repeat (10) cyc();
        check("drain_valid", evt_valid, 0);
        check("drain_sb", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
